// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_unit_pkg;

  // Instruction presented when no real fetch is available; decodes to an all-zero control word.
  localparam logic [31:0] FU_BUBBLE_INSTR = 32'h0000_0000;

  // RUN issues fetches; DRAIN discards responses still in flight from before a redirect.
  typedef enum logic {
    FU_RUN   = 1'b0,
    FU_DRAIN = 1'b1
  } fu_state_e;

  // One prefetch FIFO entry: the instruction and the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between the fetch stage and imem.
// Latency: responses return in order, at least one cycle after req&gnt.
// Backpressure: imem stalls requests by holding gnt low; responses cannot be refused.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO of {pc, instr} entries with flush; head is read combinationally.
// Latency: an entry pushed at edge N is visible at the head after edge N (no same-cycle bypass).
// Backpressure: pop on empty is ignored; push on full only lands when a pop frees the slot.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  fetch_entry_t           push_dat_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          pop_ok;
  logic          push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Entry storage; contents need no reset because count_q gates visibility.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues word fetches, buffers responses and presents PC_IF/instr_IF.
// Latency: rvalid to instr_IF is 2 edges (push, then pop); issues are capped at DEPTH in flight+buffered.
// Backpressure: PC_stall_ID holds the output and stops popping; issue stops once FIFO+outstanding=DEPTH.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter logic [31:0] PC_STEP      = 32'd1,
  parameter int unsigned DEPTH        = 2,
  parameter logic [31:0] BUBBLE_INSTR = FU_BUBBLE_INSTR
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         PC_stall_ID,
  input  logic         ctrl_branch_out,
  input  logic [31:0]  branch_PC_MEM,
  fetch_unit_if.master imem,
  output logic [31:0]  PC_IF,
  output logic [31:0]  instr_IF,
  output logic         valid_IF
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  fu_state_e     state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  // PC of the next response that will be kept: responses are in order and
  // consecutive between redirects, so a running counter stands in for a tag queue.
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [31:0]   pc_if_q, pc_if_d;
  logic [31:0]   instr_if_q, instr_if_d;
  logic          valid_if_q, valid_if_d;

  logic          req_ok, issue, push, pop;
  fetch_entry_t  push_dat, head;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .flush_i    (ctrl_branch_out),
    .head_o     (head),
    .count_o    (fifo_cnt),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Request gating, FIFO push/pop and outstanding-count accounting.
  always_comb begin
    req_ok = (state_q == FU_RUN) && !ctrl_branch_out && !reset &&
             ((SW'(fifo_cnt) + SW'(out_q)) < SW'(DEPTH));
    imem.imem_req  = req_ok;
    imem.imem_addr = fetch_pc_q;
    issue    = req_ok && imem.imem_gnt;
    push     = imem.imem_rvalid && (state_q == FU_RUN) && !ctrl_branch_out;
    pop      = !fifo_empty && !ctrl_branch_out && !PC_stall_ID;
    push_dat = '{pc: rsp_pc_q, instr: imem.imem_rdata};
    out_d    = out_q;
    unique case ({issue, imem.imem_rvalid})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
  end

  // Redirect/drain FSM, PC counters and the IF/ID-facing output register.
  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    pc_if_d    = pc_if_q;
    instr_if_d = instr_if_q;
    valid_if_d = valid_if_q;
    if (ctrl_branch_out) begin
      // Redirect beats stall; everything still in flight must be discarded.
      fetch_pc_d = branch_PC_MEM;
      rsp_pc_d   = branch_PC_MEM;
      drop_d     = out_d;
      state_d    = (out_d != '0) ? FU_DRAIN : FU_RUN;
      instr_if_d = BUBBLE_INSTR;
      valid_if_d = 1'b0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (push)  rsp_pc_d   = rsp_pc_q + PC_STEP;
      if (state_q == FU_DRAIN) begin
        if (imem.imem_rvalid) drop_d = drop_q - CW'(1);
        if (drop_d == '0)     state_d = FU_RUN;
      end
      if (!PC_stall_ID) begin
        if (pop) begin
          pc_if_d    = head.pc;
          instr_if_d = head.instr;
          valid_if_d = 1'b1;
        end else begin
          instr_if_d = BUBBLE_INSTR;
          valid_if_d = 1'b0;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FU_RUN;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      pc_if_q    <= RESET_PC;
      instr_if_q <= BUBBLE_INSTR;
      valid_if_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      pc_if_q    <= pc_if_d;
      instr_if_q <= instr_if_d;
      valid_if_q <= valid_if_d;
    end
  end

  // A push into a full FIFO without a pop means the issue gating is broken.
  always_ff @(posedge clock) begin
    if (!reset) assert (!(push && fifo_full && !pop));
  end

  assign PC_IF    = pc_if_q;
  assign instr_IF = instr_if_q;
  assign valid_IF = valid_if_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus multi-cycle sequences.
// DEPTH=4 so a 1-cycle imem plus the FIFO register stage can stream one instruction per cycle.
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch;
  logic [31:0] target;
  logic [31:0] PC_IF;
  logic [31:0] instr_IF;
  logic        valid_IF;

  int n_vec = 0;
  int n_bad = 0;
  int lat   = 1;
  int cyc   = 0;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC     (32'h0),
    .PC_STEP      (32'd1),
    .DEPTH        (4),
    .BUBBLE_INSTR (32'h0)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .PC_stall_ID     (stall),
    .ctrl_branch_out (branch),
    .branch_PC_MEM   (target),
    .imem            (bus),
    .PC_IF           (PC_IF),
    .instr_IF        (instr_IF),
    .valid_IF        (valid_IF)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hE5A0_0000;
  endfunction

  // imem model: in-order responses exactly 'lat' cycles after issue.
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t mq[$];
  always @(posedge clock) begin
    pend_t p;
    if (reset) begin
      mq.delete();
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= 32'h0;
    end else begin
      if (bus.imem_rvalid) void'(mq.pop_front());
      if (bus.imem_req && bus.imem_gnt) begin
        p.addr = bus.imem_addr;
        p.due  = cyc + lat;
        mq.push_back(p);
      end
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= mem_word(mq[0].addr);
      end else begin
        bus.imem_rvalid <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Wait (bounded) for the next valid_IF and check it carries exp_pc.
  task automatic next_valid(input string nm, input logic [31:0] exp_pc, output int bubbles);
    bubbles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (valid_IF) begin
        chk(nm, PC_IF, exp_pc);
        chk({nm, "_instr"}, instr_IF, mem_word(exp_pc));
        next_cycle();
        return;
      end
      bubbles++;
      next_cycle();
    end
    n_vec++;
    n_bad++;
    $display("FAIL %s: no valid_IF within 20 cycles, want PC %h", nm, exp_pc);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    stall  = 1'b0;
    branch = 1'b0;
    target = 32'h0;
    bus.imem_gnt = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        v;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                              input logic v, input logic [31:0] pc,
                              input logic rq, input logic [31:0] ad);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.v = v; r.pc = pc; r.req = rq; r.addr = ad;
    return r;
  endfunction

  initial begin
    int bub;
    // Cycle-by-cycle from reset release: stream start, 3-cycle stall at PC 5,
    // then branch+stall together redirecting to 0x40.
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h1));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h2));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  1'b1, 32'h3));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h1,  1'b1, 32'h4));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h2,  1'b1, 32'h5));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h3,  1'b1, 32'h6));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  1'b1, 32'h7));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h5,  1'b1, 32'h8));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h5,  1'b1, 32'h9));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h5,  1'b0, 32'hA));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h5,  1'b0, 32'hA));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h6,  1'b1, 32'hA));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h7,  1'b1, 32'hB));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  1'b1, 32'hC));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h9,  1'b1, 32'hD));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'hA,  1'b1, 32'hE));
    tbl.push_back(mk(1'b1, 1'b1, 32'h40, 1'b1, 32'hB,  1'b0, 32'hF));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b0, 32'hB,  1'b1, 32'h40));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b0, 32'hB,  1'b1, 32'h41));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b0, 32'hB,  1'b1, 32'h42));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h40, 1'b1, 32'h43));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h41, 1'b1, 32'h44));

    // Reset state, sampled while reset is still asserted.
    lat    = 1;
    reset  = 1'b1;
    stall  = 1'b0;
    branch = 1'b0;
    target = 32'h0;
    bus.imem_gnt = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_pc",    PC_IF,            32'h0);
    chk("rst_instr", instr_IF,         32'h0);
    chk("rst_valid", 32'(valid_IF),    32'd0);
    chk("rst_req",   32'(bus.imem_req), 32'd0);
    next_cycle();
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      stall  = tbl[i].stall;
      branch = tbl[i].br;
      target = tbl[i].tgt;
      @(negedge clock);
      chk($sformatf("v%0d_valid", i), 32'(valid_IF), 32'(tbl[i].v));
      chk($sformatf("v%0d_pc", i),    PC_IF,         tbl[i].pc);
      chk($sformatf("v%0d_instr", i), instr_IF,      tbl[i].v ? mem_word(tbl[i].pc) : 32'h0);
      chk($sformatf("v%0d_req", i),   32'(bus.imem_req), 32'(tbl[i].req));
      chk($sformatf("v%0d_addr", i),  bus.imem_addr, tbl[i].addr);
      next_cycle();
    end
    stall  = 1'b0;
    branch = 1'b0;

    // Branch with two responses outstanding (2-cycle imem): both are dropped.
    lat = 2;
    do_reset();
    next_valid("t3_pc0", 32'h0, bub);
    next_valid("t3_pc1", 32'h1, bub);
    next_valid("t3_pc2", 32'h2, bub);
    branch = 1'b1;
    target = 32'h40;
    @(negedge clock);
    chk("t3_br_req", 32'(bus.imem_req), 32'd0);
    next_cycle();
    branch = 1'b0;
    @(negedge clock);
    chk("t3_drain_req",   32'(bus.imem_req), 32'd0);
    chk("t3_drain_valid", 32'(valid_IF),     32'd0);
    next_cycle();
    @(negedge clock);
    chk("t3_restart_req",  32'(bus.imem_req), 32'd1);
    chk("t3_restart_addr", bus.imem_addr,     32'h40);
    chk("t3_restart_valid", 32'(valid_IF),    32'd0);
    next_cycle();
    next_valid("t3_pc40", 32'h40, bub);
    chk("t3_bubbles", bub, 32'd3);
    next_valid("t3_pc41", 32'h41, bub);
    chk("t3_pc41_gap", bub, 32'd0);

    // gnt held low for 4 cycles, then resume across the 32-bit PC wrap.
    lat = 1;
    do_reset();
    next_valid("t5_pc0", 32'h0, bub);
    next_valid("t5_pc1", 32'h1, bub);
    branch = 1'b1;
    target = 32'hFFFF_FFFE;
    next_cycle();
    branch = 1'b0;
    bus.imem_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("t5_hold%0d_req", k),   32'(bus.imem_req), 32'd1);
      chk($sformatf("t5_hold%0d_addr", k),  bus.imem_addr,     32'hFFFF_FFFE);
      chk($sformatf("t5_hold%0d_valid", k), 32'(valid_IF),     32'd0);
      next_cycle();
    end
    bus.imem_gnt = 1'b1;
    next_valid("t5_pcFE", 32'hFFFF_FFFE, bub);
    next_valid("t5_pcFF", 32'hFFFF_FFFF, bub);
    chk("t5_pcFF_gap", bub, 32'd0);
    next_valid("t5_pc0w", 32'h0, bub);
    chk("t5_pc0w_gap", bub, 32'd0);
    next_valid("t5_pc1w", 32'h1, bub);

    // Reset while draining: back to RUN at RESET_PC with nothing stale emerging.
    lat = 3;
    do_reset();
    next_valid("t6_pc0", 32'h0, bub);
    branch = 1'b1;
    target = 32'h80;
    next_cycle();
    branch = 1'b0;
    @(negedge clock);
    chk("t6_drain_req", 32'(bus.imem_req), 32'd0);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    @(negedge clock);
    chk("t6_rst_pc",    PC_IF,             32'h0);
    chk("t6_rst_valid", 32'(valid_IF),     32'd0);
    chk("t6_rst_instr", instr_IF,          32'h0);
    chk("t6_rst_req",   32'(bus.imem_req), 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("t6_run_req",  32'(bus.imem_req), 32'd1);
    chk("t6_run_addr", bus.imem_addr,     32'h0);
    next_cycle();
    next_valid("t6_after_pc0", 32'h0, bub);
    next_valid("t6_after_pc1", 32'h1, bub);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
